temp_display_driver: RTL and testbench

Downstream consumer of the DS1620 interface's 9-bit temperature word. The word is two's complement with an LSB of 0.5 °C. On each valid strobe the block captures the word, converts its magnitude to BCD with a sequential double-dabble, and latches the result into display registers. It continuously time-multiplexes four common-anode 7-segment digits showing sign/hundreds, tens, ones with a decimal point, and tenths.

---
 rtl/temp_display_driver.sv | 157 +++++++++++++++
 tb/tb_temp_display_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_display_driver.sv
// rtl/temp_display_driver.sv - DS1620 temperature word to 4-digit multiplexed 7-segment display
// Sequential double-dabble conversion feeds display registers; a free-running refresh scans the digits.
module temp_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       CLK_IN,
  input  logic       CLR,
  input  logic [8:0] TEMP,
  input  logic       TEMP_VALID,
  output logic       BUSY,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = G_BLANK;
    endcase
  endfunction

  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    bcd_adjust = b;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5) bcd_adjust[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
  endfunction

  state_t      state, state_nxt;
  logic        neg, neg_nxt, half, half_nxt;
  logic [7:0]  sr, sr_nxt;
  logic [11:0] bcd, bcd_nxt, bcd_adj;
  logic [2:0]  it, it_nxt;
  logic [8:0]  mag;
  logic [6:0]  disp_seg [4];
  logic [6:0]  disp_seg_nxt [4];
  logic [3:0]  disp_dp, disp_dp_nxt;
  logic [CNT_W-1:0] ref_cnt;
  logic        cnt_wrap;
  logic [1:0]  sel, sel_nxt;
  logic [3:0]  h_d, t_d, o_d;

  assign BUSY = (state != IDLE);
  assign h_d  = bcd[11:8];
  assign t_d  = bcd[7:4];
  assign o_d  = bcd[3:0];

  always_ff @(posedge CLK_IN or negedge CLR) begin
    if (!CLR) begin
      state       <= IDLE;
      neg         <= 1'b0;
      half        <= 1'b0;
      sr          <= '0;
      bcd         <= '0;
      it          <= '0;
      disp_seg[3] <= G_BLANK;
      disp_seg[2] <= G_BLANK;
      disp_seg[1] <= G_ZERO;
      disp_seg[0] <= G_ZERO;
      disp_dp     <= 4'b0010;
    end else begin
      state    <= state_nxt;
      neg      <= neg_nxt;
      half     <= half_nxt;
      sr       <= sr_nxt;
      bcd      <= bcd_nxt;
      it       <= it_nxt;
      disp_seg <= disp_seg_nxt;
      disp_dp  <= disp_dp_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    neg_nxt      = neg;
    half_nxt     = half;
    sr_nxt       = sr;
    bcd_nxt      = bcd;
    it_nxt       = it;
    disp_seg_nxt = disp_seg;
    disp_dp_nxt  = disp_dp;
    mag          = '0;
    bcd_adj      = '0;
    case (state)
      IDLE: begin
        if (TEMP_VALID) begin
          mag       = TEMP[8] ? (~TEMP + 9'd1) : TEMP;
          neg_nxt   = TEMP[8];
          sr_nxt    = mag[8:1];
          half_nxt  = mag[0];
          bcd_nxt   = '0;
          it_nxt    = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        bcd_adj = bcd_adjust(bcd);
        {bcd_nxt, sr_nxt} = {bcd_adj, sr} << 1;
        it_nxt = it + 3'd1;
        if (it == 3'd7) state_nxt = COMMIT;
      end
      COMMIT: begin
        if (neg && h_d != 4'd0) begin
          // -100.0 and below cannot fit in four digits
          for (int i = 0; i < 4; i++) disp_seg_nxt[i] = G_DASH;
          disp_dp_nxt = 4'b0000;
        end else begin
          disp_seg_nxt[3] = neg ? G_DASH : ((h_d == 4'd1) ? glyph(4'd1) : G_BLANK);
          disp_seg_nxt[2] = (t_d == 4'd0 && h_d == 4'd0) ? G_BLANK : glyph(t_d);
          disp_seg_nxt[1] = glyph(o_d);
          disp_seg_nxt[0] = half ? glyph(4'd5) : glyph(4'd0);
          disp_dp_nxt     = 4'b0010;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_wrap = (ref_cnt == CNT_W'(REFRESH_DIV - 1));
  assign sel_nxt  = cnt_wrap ? sel + 2'd1 : sel;

  // Outputs are registered from next-cycle select and display values so they track both without lag.
  always_ff @(posedge CLK_IN or negedge CLR) begin
    if (!CLR) begin
      ref_cnt <= '0;
      sel     <= 2'd0;
      AN      <= 4'b1110;
      SEG     <= G_ZERO;
      DP      <= 1'b1;
    end else begin
      ref_cnt <= cnt_wrap ? '0 : ref_cnt + 1'b1;
      sel     <= sel_nxt;
      AN      <= ~(4'b0001 << sel_nxt);
      SEG     <= disp_seg_nxt[sel_nxt];
      DP      <= ~disp_dp_nxt[sel_nxt];
    end
  end

endmodule

// File: tb/tb_temp_display_driver.sv
// tb/tb_temp_display_driver.sv - self-checking bench for temp_display_driver
// Randomized and directed temperatures checked against an arithmetic display model.
module tb_temp_display_driver;

  localparam int RDIV = 4;

  logic       CLK_IN = 1'b0;
  logic       CLR = 1'b0;
  logic [8:0] TEMP = '0;
  logic       TEMP_VALID = 1'b0;
  logic       BUSY;
  logic [6:0] SEG;
  logic       DP;
  logic [3:0] AN;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];

  temp_display_driver #(.REFRESH_DIV(RDIV), .CNT_W(3)) dut (
    .CLK_IN(CLK_IN), .CLR(CLR), .TEMP(TEMP), .TEMP_VALID(TEMP_VALID),
    .BUSY(BUSY), .SEG(SEG), .DP(DP), .AN(AN)
  );

  always #5 CLK_IN = ~CLK_IN;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'b1000000;
      1: glyph = 7'b1111001;
      2: glyph = 7'b0100100;
      3: glyph = 7'b0110000;
      4: glyph = 7'b0011001;
      5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;
      7: glyph = 7'b1111000;
      8: glyph = 7'b0000000;
      9: glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Display contents from the temperature rules, in plain decimal arithmetic.
  task automatic model(input logic [8:0] t);
    int v, a, ip, h, tt, o;
    v  = t[8] ? int'(t) - 512 : int'(t);
    a  = (v < 0) ? -v : v;
    ip = a / 2;
    h  = ip / 100;
    tt = (ip / 10) % 10;
    o  = ip % 10;
    for (int i = 0; i < 4; i++) exp_dp[i] = 1'b1;
    if (v < 0 && h != 0) begin
      for (int i = 0; i < 4; i++) exp_seg[i] = 7'b0111111;
    end else begin
      exp_seg[3] = (v < 0) ? 7'b0111111 : ((h == 1) ? glyph(1) : 7'b1111111);
      exp_seg[2] = (tt == 0 && h == 0) ? 7'b1111111 : glyph(tt);
      exp_seg[1] = glyph(o);
      exp_dp[1]  = 1'b0;
      exp_seg[0] = glyph((a % 2) * 5);
    end
  endtask

  task automatic scan_check(input string name);
    logic [3:0] seen;
    logic [3:0] m;
    int d;
    seen = '0;
    repeat (4 * RDIV) begin
      @(negedge CLK_IN);
      d = -1;
      for (int i = 0; i < 4; i++) begin
        m = 4'b0001 << i;
        if (AN == ~m) d = i;
      end
      checks++;
      if (d < 0) begin
        errors++;
        $display("FAIL %s an_onehot got %b", name, AN);
      end else begin
        seen[d] = 1'b1;
        checks++;
        if (SEG !== exp_seg[d] || DP !== exp_dp[d]) begin
          errors++;
          $display("FAIL %s digit%0d got seg %b dp %b exp seg %b dp %b",
                   name, d, SEG, DP, exp_seg[d], exp_dp[d]);
        end
      end
    end
    checks++;
    if (seen !== 4'hF) begin
      errors++;
      $display("FAIL %s digits_seen got %b exp 1111", name, seen);
    end
  endtask

  task automatic pulse(input logic [8:0] t);
    @(negedge CLK_IN);
    TEMP = t;
    TEMP_VALID = 1'b1;
    @(posedge CLK_IN);
    #1 TEMP_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY && n < 30) begin
      @(negedge CLK_IN);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_timeout got %b exp 0", name, BUSY);
    end
  endtask

  task automatic convert(input logic [8:0] t, input string name);
    pulse(t);
    wait_idle(name);
    model(t);
    scan_check(name);
  endtask

  task automatic test_reset;
    logic [3:0] m;
    CLR = 1'b0;
    repeat (3) @(negedge CLK_IN);
    checks++;
    if (AN !== 4'b1110 || SEG !== 7'b1000000 || DP !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got an %b seg %b dp %b busy %b exp 1110 1000000 1 0", AN, SEG, DP, BUSY);
    end
    CLR = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge CLK_IN);
      #1;
      m = 4'b0001 << ((j / RDIV) % 4);
      checks++;
      if (AN !== ~m) begin
        errors++;
        $display("FAIL reset_scan cycle%0d got %b exp %b", j, AN, ~m);
      end
    end
    model(9'h000);
    scan_check("reset_display");
  endtask

  task automatic test_latency;
    pulse(9'h032);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (BUSY !== 1'b1) begin
        errors++;
        $display("FAIL busy_high edge_k+%0d got %b exp 1", i, BUSY);
      end
      @(posedge CLK_IN);
      #1;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL busy_low edge_k+9 got %b exp 0", BUSY);
    end
    model(9'h032);
    scan_check("pos25");
  endtask

  task automatic test_directed;
    convert(9'h1CE, "neg25");
    convert(9'h1FF, "neg0p5");
    convert(9'h0FA, "pos125");
    convert(9'h000, "zero");
    convert(9'h100, "neg128");
    convert(9'h0FF, "pos127p5");
    convert(9'h19C, "neg50");
    convert(9'h0C8, "pos100");
    convert(9'h138, "neg100");
  endtask

  task automatic test_random;
    logic [8:0] t;
    for (int i = 0; i < 20; i++) begin
      t = 9'($urandom_range(0, 511));
      convert(t, $sformatf("rand_%03h", t));
    end
  endtask

  task automatic test_back_to_back;
    pulse(9'h032);
    @(posedge CLK_IN);
    @(posedge CLK_IN);
    pulse(9'h0FA);
    wait_idle("ignore");
    repeat (5) @(negedge CLK_IN);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_queue busy got %b exp 0", BUSY);
    end
    model(9'h032);
    scan_check("ignore");
  endtask

  task automatic test_reset_mid;
    pulse(9'h0FA);
    repeat (3) @(posedge CLK_IN);
    @(negedge CLK_IN);
    CLR = 1'b0;
    #1;
    checks++;
    if (AN !== 4'b1110 || SEG !== 7'b1000000 || DP !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got an %b seg %b dp %b busy %b exp 1110 1000000 1 0", AN, SEG, DP, BUSY);
    end
    repeat (2) @(negedge CLK_IN);
    CLR = 1'b1;
    repeat (20) @(negedge CLK_IN);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy got %b exp 0", BUSY);
    end
    model(9'h000);
    scan_check("midreset_display");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
